// File: rtl/px_adc_capture_engine.sv
// Multi-channel serial ADC capture engine: shared CS/SCLK, channel-tagged FIFO, APB3 control/status/data.
// Optional: define SENSEYE_ADC_TIMESTAMP_EN to tag each frame's FIFO words with a SYSCLK/16 timestamp in [31:16].
module px_adc_capture_engine #(
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_W   = 12,
    parameter int FIFO_DEPTH = 64,
    parameter int SCLK_DIV   = 4
) (
    input  logic              SYSCLK,
    input  logic              NSYSRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [3:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [NUM_CH-1:0] adc_din,
    output logic              adc_cs,
    output logic              adc_sclk,
    output logic              irq,
    output logic              tp_full,
    output logic              tp_empty,
    output logic              tp_busy
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int PW  = $clog2(2 * SCLK_DIV);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PW-1:0] PH_DIV   = PW'(SCLK_DIV);
    localparam logic [PW-1:0] PH_LAST  = PW'(2 * SCLK_DIV - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_QUIET = 2'd2,
        ST_PUSH  = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [PW-1:0]       ph_r, ph_nxt_s, ph_inc_s;
    logic [3:0]          bit_r, bit_nxt_s;
    logic [CHW-1:0]      ch_r, ch_nxt_s, first_ch_s, next_ch_s;
    logic                has_next_s;
    logic                cs_r, cs_nxt_s, sclk_r, sclk_nxt_s;
    logic                start_s, sample_en_s, push_s, frame_done_s, stop_s, last_frame_s;
    logic [NUM_CH-1:0]   fmask_r;
    logic [SAMPLE_W-1:0] sh_r [NUM_CH];

    logic                run_r, irq_en_r, ovf_r, irq_r;
    logic [NUM_CH-1:0]   mask_r;
    logic [7:0]          thr_r;
    logic [31:0]         frames_r, frame_cnt_r;

    logic [31:0]         mem_r [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]       level_r;
    logic                empty_s, full_s, pop_s, push_ok_s, ovf_set_s;
    logic                acc_s, wr_s, rd_data_s;
    logic [15:0]         ts_hi_s;
    logic [31:0]         push_word_s, ctrl_rd_s, status_rd_s, prdata_s;
    logic [1:0]          unused_s;

    assign unused_s  = PADDR[1:0];
    assign acc_s     = PSEL & PENABLE;
    assign wr_s      = acc_s & PWRITE;
    assign rd_data_s = acc_s & ~PWRITE & (PADDR[3:2] == 2'd2);
    assign empty_s   = (level_r == {LW{1'b0}});
    assign full_s    = (level_r == LVL_FULL);
    assign pop_s     = rd_data_s & ~empty_s;
    assign push_ok_s = push_s & (~full_s | pop_s);
    assign ovf_set_s = push_s & full_s & ~pop_s;
    assign ph_inc_s  = ph_r + PW'(1);
    assign last_frame_s = (frames_r != 32'd0) && ((frame_cnt_r + 32'd1) == frames_r);
    assign push_word_s  = {ts_hi_s, 4'(ch_r), 12'(sh_r[ch_r])};

`ifdef SENSEYE_ADC_TIMESTAMP_EN
    logic [3:0]  ts_pre_r;
    logic [15:0] ts_cnt_r, ts_lat_r;

    // Free-running SYSCLK/16 time base, latched on the edge where a frame's CS falls
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            ts_pre_r <= 4'd0;
            ts_cnt_r <= 16'd0;
            ts_lat_r <= 16'd0;
        end else begin
            ts_pre_r <= ts_pre_r + 4'd1;
            if (ts_pre_r == 4'hF) ts_cnt_r <= ts_cnt_r + 16'd1;
            if (start_s) ts_lat_r <= ts_cnt_r;
        end
    end
    assign ts_hi_s = ts_lat_r;
`else
    assign ts_hi_s = 16'd0;
`endif

    // Lowest enabled channel of the frame, and the next enabled channel above ch_r
    always_comb begin
        first_ch_s = '0;
        next_ch_s  = '0;
        has_next_s = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            first_ch_s = fmask_r[k] ? CHW'(k) : first_ch_s;
            next_ch_s  = (fmask_r[k] && (CHW'(k) > ch_r)) ? CHW'(k) : next_ch_s;
            has_next_s = has_next_s | (fmask_r[k] && (CHW'(k) > ch_r));
        end
    end

    // FSM state register
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) state_r <= ST_IDLE;
        else            state_r <= state_nxt_s;
    end

    // Next-state logic and next values of the serial interface
    always_comb begin
        state_nxt_s  = state_r;
        ph_nxt_s     = ph_r;
        bit_nxt_s    = bit_r;
        ch_nxt_s     = ch_r;
        cs_nxt_s     = 1'b1;
        sclk_nxt_s   = 1'b1;
        start_s      = 1'b0;
        sample_en_s  = 1'b0;
        push_s       = 1'b0;
        frame_done_s = 1'b0;
        stop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (run_r && (mask_r != '0)) begin
                    state_nxt_s = ST_CONV;
                    start_s     = 1'b1;
                    cs_nxt_s    = 1'b0;
                    sclk_nxt_s  = 1'b0;
                    ph_nxt_s    = '0;
                    bit_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                cs_nxt_s = 1'b0;
                if (ph_r == PH_LAST) begin
                    ph_nxt_s = '0;
                    if (bit_r == 4'd15) begin
                        state_nxt_s = ST_QUIET;
                        cs_nxt_s    = 1'b1;
                        sclk_nxt_s  = 1'b1;
                    end else begin
                        bit_nxt_s  = bit_r + 4'd1;
                        sclk_nxt_s = 1'b0;
                    end
                end else begin
                    ph_nxt_s    = ph_inc_s;
                    sclk_nxt_s  = (ph_inc_s >= PH_DIV);
                    sample_en_s = (ph_inc_s == PH_DIV);
                end
            end
            ST_QUIET: begin
                if (ph_r == PH_LAST) begin
                    state_nxt_s = ST_PUSH;
                    ph_nxt_s    = '0;
                    ch_nxt_s    = first_ch_s;
                end else begin
                    ph_nxt_s = ph_inc_s;
                end
            end
            ST_PUSH: begin
                push_s = 1'b1;
                if (has_next_s) begin
                    ch_nxt_s = next_ch_s;
                end else begin
                    frame_done_s = 1'b1;
                    if (!run_r || last_frame_s) begin
                        state_nxt_s = ST_IDLE;
                        stop_s      = last_frame_s;
                    end else if (mask_r != '0) begin
                        state_nxt_s = ST_CONV;
                        start_s     = 1'b1;
                        cs_nxt_s    = 1'b0;
                        sclk_nxt_s  = 1'b0;
                        ph_nxt_s    = '0;
                        bit_nxt_s   = 4'd0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Serial interface registers and per-channel shift registers
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            ph_r    <= '0;
            bit_r   <= 4'd0;
            ch_r    <= '0;
            cs_r    <= 1'b1;
            sclk_r  <= 1'b1;
            fmask_r <= '0;
            for (int k = 0; k < NUM_CH; k++) sh_r[k] <= '0;
        end else begin
            ph_r   <= ph_nxt_s;
            bit_r  <= bit_nxt_s;
            ch_r   <= ch_nxt_s;
            cs_r   <= cs_nxt_s;
            sclk_r <= sclk_nxt_s;
            if (start_s) fmask_r <= mask_r;
            if (sample_en_s) begin
                for (int k = 0; k < NUM_CH; k++) sh_r[k] <= {sh_r[k][SAMPLE_W-2:0], adc_din[k]};
            end
        end
    end

    // APB-visible registers, frame counter, sticky overflow and registered interrupt
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            run_r       <= 1'b0;
            irq_en_r    <= 1'b0;
            mask_r      <= '0;
            thr_r       <= 8'd0;
            frames_r    <= 32'd0;
            frame_cnt_r <= 32'd0;
            ovf_r       <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            if (wr_s && (PADDR[3:2] == 2'd0)) begin
                run_r    <= PWDATA[0];
                irq_en_r <= PWDATA[1];
                mask_r   <= PWDATA[8 +: NUM_CH];
                thr_r    <= PWDATA[31:24];
            end else if (stop_s) begin
                run_r <= 1'b0;
            end
            if (wr_s && (PADDR[3:2] == 2'd3)) frames_r <= PWDATA;
            if (wr_s && (PADDR[3:2] == 2'd0) && PWDATA[0]) frame_cnt_r <= 32'd0;
            else if (frame_done_s)                         frame_cnt_r <= frame_cnt_r + 32'd1;
            if (ovf_set_s)                                          ovf_r <= 1'b1;
            else if (wr_s && (PADDR[3:2] == 2'd1) && PWDATA[3])     ovf_r <= 1'b0;
            irq_r <= irq_en_r & (((thr_r != 8'd0) & (9'(level_r) >= {1'b0, thr_r})) | ovf_r);
        end
    end

    // FIFO pointers and fill level; a pop frees the slot a same-cycle push needs when full
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)     rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_ok_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge SYSCLK) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= push_word_s;
    end

    // Register readback assembly and APB read mux
    always_comb begin
        ctrl_rd_s                = 32'd0;
        ctrl_rd_s[0]             = run_r;
        ctrl_rd_s[1]             = irq_en_r;
        ctrl_rd_s[8 +: NUM_CH]   = mask_r;
        ctrl_rd_s[31:24]         = thr_r;
        status_rd_s              = 32'd0;
        status_rd_s[0]           = empty_s;
        status_rd_s[1]           = full_s;
        status_rd_s[2]           = (state_r != ST_IDLE);
        status_rd_s[3]           = ovf_r;
        status_rd_s[16 +: LW]    = level_r;
        prdata_s                 = 32'd0;
        if (PSEL && !PWRITE) begin
            case (PADDR[3:2])
                2'd0:    prdata_s = ctrl_rd_s;
                2'd1:    prdata_s = status_rd_s;
                2'd2:    prdata_s = empty_s ? 32'd0 : mem_r[rd_ptr_r];
                2'd3:    prdata_s = frames_r;
                default: prdata_s = 32'd0;
            endcase
        end else begin
            prdata_s = 32'd0;
        end
    end

    assign PRDATA   = prdata_s;
    assign PREADY   = 1'b1;
    assign PSLVERR  = rd_data_s & empty_s;
    assign adc_cs   = cs_r;
    assign adc_sclk = sclk_r;
    assign irq      = irq_r;
    assign tp_full  = full_s;
    assign tp_empty = empty_s;
    assign tp_busy  = (state_r != ST_IDLE);

endmodule
